// File: rtl/sbox.sv
// AES forward S-box: combinational byte substitution from a constant table.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] sub_c
);

    localparam logic [0:255][7:0] SBOX_LUT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_c = SBOX_LUT[in_byte];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS one per
// valid/ready handshake, computing each next key from the current one.
module key_expansion #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned RCON_W = 8;
    localparam int unsigned NWORDS = 4;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ROUNDS);
    localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    round_key_q, round_key_d;
    logic [IDX_W-1:0]    round_idx_q, round_idx_d;
    logic                key_valid_q, key_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;

    logic [WORD_W-1:0]   w0, w1, w2, w3;
    logic [WORD_W-1:0]   rot_w, sub_w, t_w;
    logic [WORD_W-1:0]   n0, n1, n2, n3;
    logic [KEY_W-1:0]    next_key_c;
    logic [RCON_W-1:0]   rcon_next_c;

    // Next round key from the current one: t = SubWord(RotWord(w3)) ^ rcon.
    assign w0    = round_key_q[0*WORD_W +: WORD_W];
    assign w1    = round_key_q[1*WORD_W +: WORD_W];
    assign w2    = round_key_q[2*WORD_W +: WORD_W];
    assign w3    = round_key_q[3*WORD_W +: WORD_W];
    assign rot_w = {w3[7:0], w3[31:8]};

    for (genvar b = 0; b < NWORDS; b++) begin : g_sbox
        sbox u_sbox (
            .in_byte (rot_w[b*8 +: 8]),
            .sub_c   (sub_w[b*8 +: 8])
        );
    end

    assign t_w         = sub_w ^ {24'h000000, rcon_q};
    assign n0          = w0 ^ t_w;
    assign n1          = w1 ^ n0;
    assign n2          = w2 ^ n1;
    assign n3          = w3 ^ n2;
    assign next_key_c  = {n3, n2, n1, n0};
    assign rcon_next_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rcon_d      = rcon_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    round_key_d = key_in;
                    round_idx_d = '0;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    rcon_d      = RCON_INIT;
                end
            end
            ST_RUN: begin
                if (key_valid_q && key_ready) begin
                    if (round_idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        key_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        rcon_d      = RCON_INIT;
                    end else begin
                        round_key_d = next_key_c;
                        round_idx_d = round_idx_q + IDX_W'(1);
                        rcon_d      = rcon_next_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rcon_q      <= RCON_INIT;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rcon_q      <= rcon_d;
        end
    end

    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
